// File: rtl/strike_cpu_gen2.sv
// rtl/strike_cpu_gen2.sv - strike board CPU: fetch/load/exec core over a registered ROM with accumulator, zero flag and jumps
// Optional return stack for CALL/RET is built when STRIKE_CALL_STACK_EN is defined; otherwise CALL/RET are NOPs and fault is 0.
module strike_cpu_gen2 #(
   parameter int AW      = 6,
   parameter int DW      = 9,
   parameter int LED_W   = 4,
   parameter int STACK_D = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   output logic [AW-1:0]    rom_addr,
   input  logic [DW-1:0]    rom_data,
   output logic [LED_W-1:0] leds,
   output logic             stop,
   output logic             fault,
   output logic [AW-1:0]    pc_dbg
);

   localparam int IW = DW - 3;

   // Reject parameter sets the instruction format cannot encode.
   if (DW < AW + 3 || LED_W > DW - 3 || STACK_D < 1 || STACK_D > 16) begin : g_param_check
      $error("strike_cpu_gen2: illegal parameter set");
   end

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_LOAD   = 2'd1,
      S_EXEC   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [2:0] OP_HALT = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_LEDS = 3'b011;
   localparam logic [2:0] OP_JP   = 3'b100;
   localparam logic [2:0] OP_JNZ  = 3'b101;
   localparam logic [2:0] OP_CALL = 3'b110;
   localparam logic [2:0] OP_RET  = 3'b111;

   state_t            state_q, state_d;
   logic [AW-1:0]     pc_q, pc_d;
   logic [DW-1:0]     ir_q, ir_d;
   logic [IW-1:0]     acc_q, acc_d;
   logic              z_q, z_d;
   logic [LED_W-1:0]  leds_q, leds_d;
   logic              stop_q, stop_d;

   logic [2:0]        opcode;
   logic [IW-1:0]     imm;
   logic [AW-1:0]     target;
   logic [AW-1:0]     pc_inc;
   logic [IW-1:0]     add_res;

   assign opcode  = ir_q[DW-1:DW-3];
   assign imm     = ir_q[IW-1:0];
   assign target  = imm[AW-1:0];
   assign pc_inc  = pc_q + 1'b1;
   assign add_res = acc_q + imm;

`ifdef STRIKE_CALL_STACK_EN
   localparam int SPW = $clog2(STACK_D + 1);

   // Storage is sized to the full SP range so SP indexes it without truncation.
   logic [AW-1:0]     stack_q [2**SPW];
   logic [SPW-1:0]    sp_q, sp_d;
   logic [SPW-1:0]    sp_dec;
   logic              fault_q, fault_d;
   logic              push_en;
   logic              stack_full;
   logic              stack_empty;

   assign sp_dec      = sp_q - 1'b1;
   assign stack_full  = (sp_q == SPW'(STACK_D));
   assign stack_empty = (sp_q == '0);
`endif

   // Next-state and datapath decode for the fetch/load/exec sequence.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      z_d     = z_q;
      leds_d  = leds_q;
      stop_d  = stop_q;
`ifdef STRIKE_CALL_STACK_EN
      sp_d    = sp_q;
      fault_d = fault_q;
      push_en = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            if (run) state_d = S_LOAD;
         end
         S_LOAD: begin
            ir_d    = rom_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode)
               OP_HALT: begin
                  stop_d  = 1'b1;
                  state_d = S_HALTED;
               end
               OP_LDI: begin
                  acc_d = imm;
                  z_d   = (imm == '0);
                  pc_d  = pc_inc;
               end
               OP_ADDI: begin
                  acc_d = add_res;
                  z_d   = (add_res == '0);
                  pc_d  = pc_inc;
               end
               OP_LEDS: begin
                  leds_d = imm[LED_W-1:0];
                  pc_d   = pc_inc;
               end
               OP_JP: begin
                  pc_d = target;
               end
               OP_JNZ: begin
                  pc_d = z_q ? pc_inc : target;
               end
`ifdef STRIKE_CALL_STACK_EN
               // Overflow and underflow leave PC and SP untouched and park the core.
               OP_CALL: begin
                  if (stack_full) begin
                     fault_d = 1'b1;
                     stop_d  = 1'b1;
                     state_d = S_HALTED;
                  end else begin
                     push_en = 1'b1;
                     sp_d    = sp_q + 1'b1;
                     pc_d    = target;
                  end
               end
               OP_RET: begin
                  if (stack_empty) begin
                     fault_d = 1'b1;
                     stop_d  = 1'b1;
                     state_d = S_HALTED;
                  end else begin
                     sp_d = sp_dec;
                     pc_d = stack_q[sp_dec];
                  end
               end
`else
               OP_CALL: pc_d = pc_inc;
               OP_RET:  pc_d = pc_inc;
`endif
               default: pc_d = pc_inc;
            endcase
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // State register; reset discards any instruction in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         z_q     <= 1'b1;
         leds_q  <= '0;
         stop_q  <= 1'b0;
`ifdef STRIKE_CALL_STACK_EN
         sp_q    <= '0;
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         leds_q  <= leds_d;
         stop_q  <= stop_d;
`ifdef STRIKE_CALL_STACK_EN
         sp_q    <= sp_d;
         fault_q <= fault_d;
`endif
      end
   end

`ifdef STRIKE_CALL_STACK_EN
   // Return-address storage; a push landing on a reset edge is dropped.
   always_ff @(posedge clock) begin
      if (!reset && push_en) stack_q[sp_q] <= pc_inc;
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign rom_addr = pc_q;
   assign pc_dbg   = pc_q;
   assign leds     = leds_q;
   assign stop     = stop_q;

endmodule
